// File: rtl/inference_request_filter.sv
// Ingress filter: classifies each frame from its first two beats and forwards only
// IPv4/UDP inference requests to the packet processor; everything else is dropped and counted.
module inference_request_filter #(
  parameter int          TDATA_WIDTH        = 256,
  parameter int          TUSER_WIDTH        = 128,
  parameter logic [15:0] INFERENCE_UDP_PORT = 16'h1F90,
  localparam int         TKEEP_WIDTH        = TDATA_WIDTH / 8
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,
  input  logic [TDATA_WIDTH-1:0] packet_in_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] packet_in_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0] packet_in_axis_tuser,
  input  logic                   packet_in_axis_tvalid,
  output logic                   packet_in_axis_tready,
  input  logic                   packet_in_axis_tlast,
  output logic [TDATA_WIDTH-1:0] packet_out_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] packet_out_axis_tkeep,
  output logic [TUSER_WIDTH-1:0] packet_out_axis_tuser,
  output logic                   packet_out_axis_tvalid,
  input  logic                   packet_out_axis_tready,
  output logic                   packet_out_axis_tlast,
  output logic [31:0]            match_count,
  output logic [31:0]            drop_count
);

  // Handshake: a beat moves on an interface in the cycle where valid && ready are both 1;
  // the output register holds all payload fields stable while tvalid=1 and tready=0.

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_EMIT0 = 3'd2,
    S_EMIT1 = 3'd3,
    S_PASS  = 3'd4,
    S_DROP  = 3'd5
  } state_t;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [TKEEP_WIDTH-1:0] keep;
    logic [TUSER_WIDTH-1:0] user;
    logic                   last;
  } beat_t;

  state_t      state_q, state_d;
  beat_t       hold0_q, hold0_d;
  beat_t       hold1_q, hold1_d;
  beat_t       out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] match_count_q, match_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  beat_t in_beat;
  logic  out_free;
  logic  in_ready;
  logic  in_fire;
  logic  hdr0_ok;
  logic  is_match;
  logic  match_inc;
  logic  drop_inc;

  assign in_beat  = {packet_in_axis_tdata, packet_in_axis_tkeep,
                     packet_in_axis_tuser, packet_in_axis_tlast};
  assign out_free = !out_valid_q || packet_out_axis_tready;
  assign in_fire  = packet_in_axis_tvalid && in_ready;

  // Beat 0 fields come from the hold register; the UDP port is checked on the live beat 1.
  assign hdr0_ok  = (hold0_q.data[8*12 +: 8] == 8'h08) &&
                    (hold0_q.data[8*13 +: 8] == 8'h00) &&
                    (hold0_q.data[8*14 +: 8] == 8'h45) &&
                    (hold0_q.data[8*23 +: 8] == 8'h11);
  assign is_match = hdr0_ok &&
                    ({packet_in_axis_tdata[39:32], packet_in_axis_tdata[47:40]} == INFERENCE_UDP_PORT) &&
                    (packet_in_axis_tkeep[5:4] == 2'b11);

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q <= S_HDR0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR0:  if (in_fire && !packet_in_axis_tlast) state_d = S_HDR1;
      S_HDR1: begin
        if (in_fire) begin
          if (is_match)                  state_d = S_EMIT0;
          else if (packet_in_axis_tlast) state_d = S_HDR0;
          else                           state_d = S_DROP;
        end
      end
      S_EMIT0: if (out_free) state_d = S_EMIT1;
      S_EMIT1: if (out_free) state_d = hold1_q.last ? S_HDR0 : S_PASS;
      S_PASS:  if (in_fire && packet_in_axis_tlast) state_d = S_HDR0;
      S_DROP:  if (in_fire && packet_in_axis_tlast) state_d = S_HDR0;
      default: state_d = S_HDR0;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    match_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      S_HDR0: begin
        in_ready = 1'b1;
        drop_inc = in_fire && packet_in_axis_tlast;
      end
      S_HDR1: begin
        in_ready  = 1'b1;
        match_inc = in_fire && is_match;
        drop_inc  = in_fire && !is_match;
      end
      S_PASS:  in_ready = out_free;
      S_DROP:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign packet_in_axis_tready = in_ready && axis_resetn;

  always_comb begin
    hold0_d       = hold0_q;
    hold1_d       = hold1_q;
    out_d         = out_q;
    out_valid_d   = out_valid_q;
    match_count_d = match_count_q + {31'd0, match_inc};
    drop_count_d  = drop_count_q + {31'd0, drop_inc};
    if (out_valid_q && packet_out_axis_tready) out_valid_d = 1'b0;
    case (state_q)
      S_HDR0: if (in_fire) hold0_d = in_beat;
      S_HDR1: if (in_fire) hold1_d = in_beat;
      S_EMIT0: begin
        if (out_free) begin
          out_d       = hold0_q;
          out_valid_d = 1'b1;
        end
      end
      S_EMIT1: begin
        if (out_free) begin
          out_d       = hold1_q;
          out_valid_d = 1'b1;
        end
      end
      S_PASS: begin
        if (in_fire) begin
          out_d       = in_beat;
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      hold0_q       <= '0;
      hold1_q       <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      match_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      hold0_q       <= hold0_d;
      hold1_q       <= hold1_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      match_count_q <= match_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign packet_out_axis_tdata  = out_q.data;
  assign packet_out_axis_tkeep  = out_q.keep;
  assign packet_out_axis_tuser  = out_q.user;
  assign packet_out_axis_tlast  = out_q.last;
  assign packet_out_axis_tvalid = out_valid_q;
  assign match_count            = match_count_q;
  assign drop_count             = drop_count_q;

endmodule

// File: tb/tb_inference_request_filter.sv
// Bench for inference_request_filter: random frames classified by a byte-level
// reference model, output beats checked in order against an expected queue.
module tb_inference_request_filter;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = 32;
  localparam int W  = DW + KW + UW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_tdata = '0;
  logic [KW-1:0] in_tkeep = '0;
  logic [UW-1:0] in_tuser = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic          in_tlast = 1'b0;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic [UW-1:0] out_tuser;
  logic          out_tvalid;
  logic          out_tready = 1'b1;
  logic          out_tlast;
  logic [31:0]   match_count;
  logic [31:0]   drop_count;

  always #5 clk = ~clk;

  inference_request_filter dut (
    .axis_aclk              (clk),
    .axis_resetn            (rst_n),
    .packet_in_axis_tdata   (in_tdata),
    .packet_in_axis_tkeep   (in_tkeep),
    .packet_in_axis_tuser   (in_tuser),
    .packet_in_axis_tvalid  (in_tvalid),
    .packet_in_axis_tready  (in_tready),
    .packet_in_axis_tlast   (in_tlast),
    .packet_out_axis_tdata  (out_tdata),
    .packet_out_axis_tkeep  (out_tkeep),
    .packet_out_axis_tuser  (out_tuser),
    .packet_out_axis_tvalid (out_tvalid),
    .packet_out_axis_tready (out_tready),
    .packet_out_axis_tlast  (out_tlast),
    .match_count            (match_count),
    .drop_count             (drop_count)
  );

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] m_match = '0;
  logic [31:0] m_drop = '0;
  int          cyc = 0;
  int          tr_mode = 0;
  int          tr_idx = 0;
  int          first_valid_cyc = -1;
  int          acc1_cyc = 0;

  logic [DW-1:0] f_data[8];
  logic [KW-1:0] f_keep[8];
  logic [UW-1:0] f_user[8];
  int            f_len = 0;

  wire [W-1:0] got_w = {out_tdata, out_tkeep, out_tuser, out_tlast};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: every output transfer must equal the head of the expected queue.
  initial begin : monitor
    bit           stall_prev;
    logic [W-1:0] stall_word;
    logic [W-1:0] exp_w;
    stall_prev = 1'b0;
    stall_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_tready = 1'b1;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (out_tvalid !== 1'b1 || got_w !== stall_word) begin
            errors++;
            $display("FAIL out_stable: got valid=%b word=%h required valid=1 word=%h",
                     out_tvalid, got_w, stall_word);
          end
        end
        case (tr_mode)
          0: out_tready = 1'b1;
          1: begin
            out_tready = (tr_idx % 4 == 0) || (tr_idx % 4 == 3);
            tr_idx++;
          end
          default: out_tready = 1'($urandom_range(0, 1));
        endcase
        if (out_tvalid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_tvalid === 1'b1 && out_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got word=%h required no beat", got_w);
          end else begin
            exp_w = exp_q.pop_front();
            if (got_w !== exp_w) begin
              errors++;
              $display("FAIL out_beat: got %h required %h", got_w, exp_w);
            end
          end
        end
        stall_prev = (out_tvalid === 1'b1) && !out_tready;
        stall_word = got_w;
      end
    end
  end

  function automatic logic [7:0] fbyte(input int n);
    logic [DW-1:0] d;
    d = f_data[n / 32];
    return d[8 * (n % 32) +: 8];
  endfunction

  // Reference classification straight from the frame bytes.
  function automatic bit frame_is_request();
    if (f_len < 2) return 1'b0;
    return fbyte(12) == 8'h08 && fbyte(13) == 8'h00 && fbyte(14) == 8'h45 &&
           fbyte(23) == 8'h11 && {fbyte(36), fbyte(37)} == 16'h1F90 &&
           f_keep[1][4] && f_keep[1][5];
  endfunction

  task automatic build_frame(input int len, input logic [15:0] etype, input logic [7:0] vihl,
                             input logic [7:0] proto, input logic [15:0] port, input logic [1:0] k54);
    f_len = len;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < 8; w++) f_data[i][32*w +: 32] = $urandom;
      for (int w = 0; w < 4; w++) f_user[i][32*w +: 32] = $urandom;
      f_keep[i] = (i == len - 1) ? ($urandom | 32'h1) : '1;
    end
    f_data[0][8*12 +: 8] = etype[15:8];
    f_data[0][8*13 +: 8] = etype[7:0];
    f_data[0][8*14 +: 8] = vihl;
    f_data[0][8*23 +: 8] = proto;
    if (len > 1) begin
      f_data[1][39:32] = port[15:8];
      f_data[1][47:40] = port[7:0];
      f_keep[1][5:4]   = k54;
    end
  endtask

  task automatic build_request(input int len);
    build_frame(len, 16'h0800, 8'h45, 8'h11, 16'h1F90, 2'b11);
  endtask

  task automatic model_frame();
    if (frame_is_request()) begin
      for (int i = 0; i < f_len; i++)
        exp_q.push_back({f_data[i], f_keep[i], f_user[i], (i == f_len - 1)});
      m_match++;
    end else begin
      m_drop++;
    end
  endtask

  task automatic send_beat(input int idx, input bit chk, output bit ok);
    int budget;
    bit acc;
    budget = 300;
    acc = 1'b0;
    @(negedge clk);
    in_tdata  = f_data[idx];
    in_tkeep  = f_keep[idx];
    in_tuser  = f_user[idx];
    in_tlast  = (idx == f_len - 1);
    in_tvalid = 1'b1;
    while (!acc && budget > 0) begin
      #2;
      if (chk && out_tvalid === 1'b1 && !out_tready) begin
        checks++;
        if (in_tready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_stall: got %b required 0", in_tready);
        end
      end
      if (in_tready === 1'b1) begin
        acc = 1'b1;
        if (idx == 1) acc1_cyc = cyc;
        @(posedge clk);
      end else begin
        budget--;
        @(negedge clk);
      end
    end
    ok = acc;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL in_accept_timeout: beat %0d not accepted, required accept", idx);
      in_tvalid = 1'b0;
    end
  endtask

  task automatic send_frame(input bit gaps, input bit chk);
    bit ok;
    model_frame();
    for (int i = 0; i < f_len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        in_tvalid = 1'b0;
      end
      send_beat(i, chk && i >= 2, ok);
      if (!ok) return;
    end
    @(negedge clk);
    in_tvalid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int budget;
    budget = 400;
    repeat (2) @(negedge clk);
    while ((exp_q.size() != 0 || out_tvalid === 1'b1) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    ok = (exp_q.size() == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    in_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    exp_q.delete();
    m_match = '0;
    m_drop = '0;
    first_valid_cyc = -1;
    tr_mode = 0;
    tr_idx = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_tdata = {8{32'hA5A5_5A5A}};
    in_tvalid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", out_tvalid); end
    checks++; if (out_tdata !== '0) begin errors++; $display("FAIL rst_data: got %h required 0", out_tdata); end
    checks++; if (out_tkeep !== '0) begin errors++; $display("FAIL rst_keep: got %h required 0", out_tkeep); end
    checks++; if (out_tuser !== '0) begin errors++; $display("FAIL rst_user: got %h required 0", out_tuser); end
    checks++; if (out_tlast !== 1'b0) begin errors++; $display("FAIL rst_last: got %b required 0", out_tlast); end
    checks++; if (match_count !== 32'd0) begin errors++; $display("FAIL rst_match: got %0d required 0", match_count); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL rst_drop: got %0d required 0", drop_count); end
    checks++; if (in_tready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_tready); end
    in_tvalid = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_match();
    bit ok;
    do_reset();
    build_request(4);
    send_frame(1'b0, 1'b0);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL match_drain: %0d beats missing, required 0", exp_q.size()); end
    checks++;
    if (first_valid_cyc - acc1_cyc !== 2) begin
      errors++;
      $display("FAIL match_latency: got %0d cycles required 2", first_valid_cyc - acc1_cyc);
    end
    checks++; if (match_count !== 32'd1) begin errors++; $display("FAIL match_count: got %0d required 1", match_count); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL match_drop: got %0d required 0", drop_count); end
  endtask

  task automatic test_port_mismatch();
    bit ok;
    do_reset();
    build_frame(3, 16'h0800, 8'h45, 8'h11, 16'h0035, 2'b11);
    send_frame(1'b0, 1'b0);
    build_request(2);
    send_frame(1'b0, 1'b0);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL port_drain: %0d beats missing, required 0", exp_q.size()); end
    checks++; if (drop_count !== m_drop) begin errors++; $display("FAIL port_drop: got %0d required %0d", drop_count, m_drop); end
    checks++; if (match_count !== m_match) begin errors++; $display("FAIL port_match: got %0d required %0d", match_count, m_match); end
  endtask

  task automatic test_non_ipv4();
    bit ok;
    do_reset();
    build_frame(3, 16'h86DD, 8'h45, 8'h11, 16'h1F90, 2'b11);
    send_frame(1'b0, 1'b0);
    checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL ipv6_drop: got %0d required 1", drop_count); end
    build_request(1);
    send_frame(1'b0, 1'b0);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_drain: %0d beats missing, required 0", exp_q.size()); end
    checks++; if (drop_count !== 32'd2) begin errors++; $display("FAIL short_drop: got %0d required 2", drop_count); end
    checks++; if (match_count !== 32'd0) begin errors++; $display("FAIL short_match: got %0d required 0", match_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    tr_mode = 1;
    build_request(6);
    send_frame(1'b0, 1'b1);
    wait_drain(ok);
    tr_mode = 0;
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: %0d beats missing, required 0", exp_q.size()); end
    checks++; if (match_count !== 32'd1) begin errors++; $display("FAIL bp_match: got %0d required 1", match_count); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    build_request(5);
    model_frame();
    for (int i = 0; i < 3; i++) begin
      send_beat(i, 1'b0, ok);
      if (!ok) break;
    end
    @(negedge clk);
    in_tdata  = f_data[3];
    in_tkeep  = f_keep[3];
    in_tuser  = f_user[3];
    in_tlast  = 1'b0;
    in_tvalid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", out_tvalid); end
    checks++; if (match_count !== 32'd0) begin errors++; $display("FAIL midrst_match: got %0d required 0", match_count); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL midrst_drop: got %0d required 0", drop_count); end
    exp_q.delete();
    m_match = '0;
    m_drop = '0;
    in_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    build_frame(3, 16'h0800, 8'h46, 8'h11, 16'h1F90, 2'b11);
    send_frame(1'b0, 1'b0);
    build_request(2);
    send_frame(1'b0, 1'b0);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_drain: %0d beats missing, required 0", exp_q.size()); end
    checks++; if (match_count !== 32'd1) begin errors++; $display("FAIL midrst_match2: got %0d required 1", match_count); end
    checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL midrst_drop2: got %0d required 1", drop_count); end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    do_reset();
    @(negedge clk);
    force dut.match_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.match_count_q;
    #1;
    checks++; if (match_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset: got %h required ffffffff", match_count); end
    m_match = 32'hFFFF_FFFF;
    build_request(3);
    send_frame(1'b0, 1'b0);
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain: %0d beats missing, required 0", exp_q.size()); end
    checks++; if (match_count !== m_match) begin errors++; $display("FAIL wrap_match: got %h required %h", match_count, m_match); end
  endtask

  task automatic test_random();
    bit ok;
    int kind;
    int len;
    do_reset();
    tr_mode = 2;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 7);
      len  = $urandom_range(1, 6);
      case (kind)
        0:       build_frame(len, 16'h86DD, 8'h45, 8'h11, 16'h1F90, 2'b11);
        1:       build_frame(len, 16'h0800, 8'h46, 8'h11, 16'h1F90, 2'b11);
        2:       build_frame(len, 16'h0800, 8'h45, 8'h06, 16'h1F90, 2'b11);
        3:       build_frame(len, 16'h0800, 8'h45, 8'h11, 16'(16'h1F91 + $urandom_range(0, 9)), 2'b11);
        4:       build_frame(len, 16'h0800, 8'h45, 8'h11, 16'h1F90, 2'($urandom_range(0, 2)));
        default: build_request(len);
      endcase
      send_frame(1'b1, 1'b0);
    end
    wait_drain(ok);
    tr_mode = 0;
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain: %0d beats missing, required 0", exp_q.size()); end
    checks++; if (match_count !== m_match) begin errors++; $display("FAIL rand_match: got %0d required %0d", match_count, m_match); end
    checks++; if (drop_count !== m_drop) begin errors++; $display("FAIL rand_drop: got %0d required %0d", drop_count, m_drop); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_port_mismatch();
    test_non_ipv4();
    test_backpressure();
    test_reset_mid_frame();
    test_counter_wrap();
    test_random();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inference_request_filter.md
Name: inference_request_filter

Overview:
- Ingress stage that sits directly upstream of the inference packet processor. It drives that processor's packet input AXI4-Stream.
- Classifies each incoming Ethernet frame from the first two beats:
  - Match: IPv4, header length 5, UDP, destination port == INFERENCE_UDP_PORT. Matching frames are forwarded unchanged.
  - Non-match: all other frames are silently dropped and counted.

Parameters:
- TDATA_WIDTH, 256, stream data width. Fixed at 256: header fields are located within beats 0 and 1.
- TUSER_WIDTH, 128, sideband width, carried through unchanged.
- INFERENCE_UDP_PORT, 16'h1F90, UDP destination port that marks an inference request.
- TKEEP_WIDTH (localparam), TDATA_WIDTH/8, byte-enable width.

Ports:
- axis_aclk  in  1  clock
- axis_resetn  in  1  asynchronous active-low reset
- packet_in_axis_tdata  in  TDATA_WIDTH  frame data; wire byte n at tdata[8n+7:8n]
- packet_in_axis_tkeep  in  TKEEP_WIDTH  byte enables
- packet_in_axis_tuser  in  TUSER_WIDTH  sideband, meaningful on beat 0
- packet_in_axis_tvalid  in  1  input valid
- packet_in_axis_tready  out  1  input ready
- packet_in_axis_tlast  in  1  last beat of frame
- packet_out_axis_tdata  out  TDATA_WIDTH  forwarded data
- packet_out_axis_tkeep  out  TKEEP_WIDTH  forwarded byte enables
- packet_out_axis_tuser  out  TUSER_WIDTH  forwarded sideband
- packet_out_axis_tvalid  out  1  output valid
- packet_out_axis_tready  in  1  output ready
- packet_out_axis_tlast  out  1  forwarded last
- match_count  out  32  frames forwarded, wraps at 2^32
- drop_count  out  32  frames dropped, wraps at 2^32

Behaviour:
- Reset (axis_resetn=0, asynchronous):
  - State goes to S_HDR0.
  - packet_out_axis_tvalid=0.
  - All out data/keep/user/last = 0.
  - Both counters = 0.
  - Hold registers cleared.
  - packet_in_axis_tready=0 while reset is asserted.
- A reset asserted mid-frame abandons the frame with no output and no count update. The first beat accepted after reset is treated as beat 0.
- Handshake:
  - A beat transfers when valid && ready on that interface.
  - The output is a single register stage: tvalid/tdata/tkeep/tuser/tlast hold stable while tvalid=1 && tready=0.
- Header checks, with byte indices relative to the frame start:
  - Beat 0: EtherType bytes 12-13 == 08 00; byte 14 == 8'h45; protocol byte 23 == 8'h11.
  - Beat 1 (frame bytes 32-63): UDP dest port bytes 36-37, i.e. beat-1 tdata[39:32] is the MSB and tdata[47:40] the LSB.
  - Match requires all checks true and beat-1 tkeep[5:4] == 2'b11.
- States:
  - S_HDR0: tready=1.
    - Beat captured into hold0 (data, keep, user, last).
    - If tlast: drop_count++, stay in S_HDR0 (a frame shorter than 2 beats never matches).
    - Else go to S_HDR1.
  - S_HDR1: tready=1.
    - Beat captured into hold1 and evaluated in the same cycle.
    - Match: match_count++, go to S_EMIT0.
    - Mismatch: drop_count++. If tlast go to S_HDR0, else S_DROP.
  - S_EMIT0: tready=0.
    - Output register loaded with hold0 when the register is empty or being drained; out tvalid=1 on the next cycle.
    - On load go to S_EMIT1.
  - S_EMIT1: tready=0.
    - Output register loaded with hold1 on the next free slot.
    - If hold1.last go to S_HDR0, else S_PASS.
  - S_PASS:
    - tready = !out_tvalid || out_tready.
    - Each accepted beat is loaded into the output register unchanged.
    - Accepted tlast goes to S_HDR0.
  - S_DROP: tready=1; beats discarded; accepted tlast goes to S_HDR0.
- Latency:
  - The first output beat is valid 2 cycles after beat 1 is accepted, with out_tready=1.
  - Thereafter one beat per cycle with no bubbles while both sides stream.
- Counters:
  - Increment exactly once per frame, at the decision point.
  - Match and drop never both increment in the same cycle.
  - Plain binary wrap from 32'hFFFFFFFF to 0.
- Forwarded frames are bit-exact (data, keep, user, last) and in order. No beat is duplicated or lost under any out_tready pattern.

Test Plan:
- Matching frame: 4 beats, UDP port 0x1F90, out_tready=1 -> 4 identical beats out, tlast on beat 3, first out beat 2 cycles after beat-1 accept, match_count=1, drop_count=0.
- Mismatched port: port 0x0035, 3-beat frame, then a matching 2-beat frame -> first frame absent from output, drop_count=1; second forwarded, match_count=1.
- Non-IPv4: EtherType 0x86DD -> dropped, drop_count=1. Single-beat frame (tlast on beat 0) -> dropped, drop_count=2, no output.
- Backpressure: out_tready toggling 1,0,0,1 during a matching 6-beat frame -> output stable while stalled, all 6 beats delivered in order, input tready deasserted during stalls in S_PASS.
- Reset mid-frame: assert axis_resetn=0 during beat 3 of a matching frame -> tvalid=0 and both counts 0 immediately; the next frame is classified correctly.
- Counter wrap: force match_count to 32'hFFFFFFFF, send a matching frame -> match_count=0.
